// File: rtl/load_store_unit.sv
// Memory stage: byte-lane steered loads/stores over a req/ack data bus with misalignment and timeout faults.
// Pass-through ops retire in 1 cycle; memory ops stall upstream from accept until the ack (or timeout) cycle.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [5:0]  in_instr_id,
  input  logic [31:0] in_mem_addr,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_exec_result,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_rd_write_en,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_rd_write_en,
  output logic [31:0] wb_result,
  output logic        misaligned_load,
  output logic        misaligned_store,
  output logic        bus_error,
  output logic [31:0] fault_addr
);
  localparam logic [5:0] INSTR_LB  = 6'h10;
  localparam logic [5:0] INSTR_LH  = 6'h11;
  localparam logic [5:0] INSTR_LW  = 6'h12;
  localparam logic [5:0] INSTR_LBU = 6'h13;
  localparam logic [5:0] INSTR_LHU = 6'h14;
  localparam logic [5:0] INSTR_SB  = 6'h15;
  localparam logic [5:0] INSTR_SH  = 6'h16;
  localparam logic [5:0] INSTR_SW  = 6'h17;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [4:0]    rd_q, rd_d;
  logic          rd_we_q, rd_we_d;
  logic          req_q, req_d, we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_result_q, wb_result_d, fault_q, fault_d;
  logic          mis_ld_q, mis_ld_d, mis_st_q, mis_st_d, berr_q, berr_d;
  logic          stall;

  logic        in_load, in_store, in_half, in_word, in_aligned;
  logic [31:0] rshift, load_val;

  always_comb begin
    in_load    = (in_instr_id == INSTR_LB) || (in_instr_id == INSTR_LH) || (in_instr_id == INSTR_LW) ||
                 (in_instr_id == INSTR_LBU) || (in_instr_id == INSTR_LHU);
    in_store   = (in_instr_id == INSTR_SB) || (in_instr_id == INSTR_SH) || (in_instr_id == INSTR_SW);
    in_half    = (in_instr_id == INSTR_LH) || (in_instr_id == INSTR_LHU) || (in_instr_id == INSTR_SH);
    in_word    = (in_instr_id == INSTR_LW) || (in_instr_id == INSTR_SW);
    in_aligned = !((in_half && in_mem_addr[0]) || (in_word && (in_mem_addr[1:0] != 2'b00)));
  end

  // Aligned halfwords have addr[0]=0, so one shift by the byte lane serves both widths.
  always_comb begin
    rshift   = dmem_rdata >> {addr_q[1:0], 3'b000};
    load_val = dmem_rdata;
    case (op_q)
      INSTR_LB:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      INSTR_LBU: load_val = {24'h0, rshift[7:0]};
      INSTR_LH:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      INSTR_LHU: load_val = {16'h0, rshift[15:0]};
      default:   load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  op_d = op_q;  addr_d = addr_q;
    rd_d = rd_q;  rd_we_d = rd_we_q;  req_d = req_q;  we_d = we_q;
    wdata_d = wdata_q;  wstrb_d = wstrb_q;
    wb_valid_d = 1'b0;  wb_we_d = 1'b0;  wb_rd_d = wb_rd_q;  wb_result_d = wb_result_q;
    mis_ld_d = 1'b0;  mis_st_d = 1'b0;  berr_d = 1'b0;  fault_d = fault_q;
    stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && (in_load || in_store) && in_aligned) begin
          stall   = 1'b1;
          state_d = WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = in_store;
          op_d    = in_instr_id;
          addr_d  = in_mem_addr;
          rd_d    = in_rd_addr;
          rd_we_d = in_rd_write_en && (in_rd_addr != 5'd0);
          wdata_d = in_store_data;
          wstrb_d = 4'b0000;
          if (in_instr_id == INSTR_SB) begin
            wdata_d = {4{in_store_data[7:0]}};
            wstrb_d = 4'b0001 << in_mem_addr[1:0];
          end else if (in_instr_id == INSTR_SH) begin
            wdata_d = {2{in_store_data[15:0]}};
            wstrb_d = 4'b0011 << {in_mem_addr[1], 1'b0};
          end else if (in_instr_id == INSTR_SW) begin
            wstrb_d = 4'b1111;
          end
        end else if (in_valid && (in_load || in_store)) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = in_rd_addr;
          mis_ld_d   = in_load;
          mis_st_d   = in_store;
          fault_d    = in_mem_addr;
        end else if (in_valid) begin
          wb_valid_d  = 1'b1;
          wb_rd_d     = in_rd_addr;
          wb_we_d     = in_rd_write_en && (in_rd_addr != 5'd0);
          wb_result_d = in_exec_result;
        end
      end
      WAIT: begin
        if (dmem_ack || (cnt_q == CW'(TIMEOUT_CYCLES))) begin
          state_d    = IDLE;
          cnt_d      = '0;
          req_d      = 1'b0;
          we_d       = 1'b0;
          wstrb_d    = 4'b0000;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (dmem_ack) begin
            if (!we_q) begin
              wb_we_d     = rd_we_q;
              wb_result_d = load_val;
            end
          end else begin
            berr_d  = 1'b1;
            fault_d = addr_q;
          end
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;  cnt_q <= '0;  op_q <= '0;  addr_q <= '0;
      rd_q <= '0;  rd_we_q <= 1'b0;  req_q <= 1'b0;  we_q <= 1'b0;
      wdata_q <= '0;  wstrb_q <= '0;
      wb_valid_q <= 1'b0;  wb_we_q <= 1'b0;  wb_rd_q <= '0;  wb_result_q <= '0;
      mis_ld_q <= 1'b0;  mis_st_q <= 1'b0;  berr_q <= 1'b0;  fault_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  op_q <= op_d;  addr_q <= addr_d;
      rd_q <= rd_d;  rd_we_q <= rd_we_d;  req_q <= req_d;  we_q <= we_d;
      wdata_q <= wdata_d;  wstrb_q <= wstrb_d;
      wb_valid_q <= wb_valid_d;  wb_we_q <= wb_we_d;  wb_rd_q <= wb_rd_d;  wb_result_q <= wb_result_d;
      mis_ld_q <= mis_ld_d;  mis_st_q <= mis_st_d;  berr_q <= berr_d;  fault_q <= fault_d;
    end
  end

  assign stall_out        = rst_n && stall;
  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = {addr_q[31:2], 2'b00};
  assign dmem_wdata       = wdata_q;
  assign dmem_wstrb       = wstrb_q;
  assign wb_valid         = wb_valid_q;
  assign wb_rd_addr       = wb_rd_q;
  assign wb_rd_write_en   = wb_we_q;
  assign wb_result        = wb_result_q;
  assign misaligned_load  = mis_ld_q;
  assign misaligned_store = mis_st_q;
  assign bus_error        = berr_q;
  assign fault_addr       = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected writeback bundles.
module tb_load_store_unit;
  localparam logic [5:0] ADD = 6'h01, LB = 6'h10, LH = 6'h11, LW = 6'h12, LBU = 6'h13,
                         LHU = 6'h14, SH = 6'h16, SW = 6'h17;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_rd_write_en, dmem_ack;
  logic [5:0]  in_instr_id;
  logic [31:0] in_mem_addr, in_store_data, in_exec_result, dmem_rdata;
  logic [4:0]  in_rd_addr;
  logic        stall_out, dmem_req, dmem_we, wb_valid, wb_rd_write_en;
  logic        misaligned_load, misaligned_store, bus_error;
  logic [31:0] dmem_addr, dmem_wdata, wb_result, fault_addr;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  wb_rd_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res; logic chk_res; logic [4:0] rd; logic we;
    logic ml; logic ms; logic be; logic [31:0] fa;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr_id(in_instr_id),
    .in_mem_addr(in_mem_addr), .in_store_data(in_store_data), .in_exec_result(in_exec_result),
    .in_rd_addr(in_rd_addr), .in_rd_write_en(in_rd_write_en), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd_addr(wb_rd_addr), .wb_rd_write_en(wb_rd_write_en), .wb_result(wb_result),
    .misaligned_load(misaligned_load), .misaligned_store(misaligned_store),
    .bus_error(bus_error), .fault_addr(fault_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; the caller is left just after that edge.
  task automatic drive(input logic [5:0] id, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] res, input logic [4:0] rd, input logic we,
                       input logic exp_stall, input string tag);
    in_valid = 1'b1; in_instr_id = id; in_mem_addr = addr; in_store_data = sdata;
    in_exec_result = res; in_rd_addr = rd; in_rd_write_en = we;
    #1;
    chk({tag, "_accept_stall"}, 32'(stall_out), 32'(exp_stall));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] res, input logic chk_res, input logic [4:0] rd,
                      input logic we, input logic ml, input logic ms, input logic be,
                      input logic [31:0] fa);
    exp_t e;
    e.res = res; e.chk_res = chk_res; e.rd = rd; e.we = we;
    e.ml = ml; e.ms = ms; e.be = be; e.fa = fa;
    sbq.push_back(e);
  endtask

  task automatic expect_wb(input string tag);
    exp_t e;
    int n = 0;
    while (!wb_valid && n < 8) begin
      tick();
      n++;
    end
    if (!wb_valid) begin
      checks++;
      errors++;
      $error("FAIL %s_wb_timeout observed=no_wb_valid expected=wb_valid", tag);
    end else if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_unexpected_wb observed=wb_valid expected=empty_scoreboard", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_wb_latency"}, 32'(n), 32'd0);
      chk({tag, "_rd"}, 32'(wb_rd_addr), 32'(e.rd));
      chk({tag, "_we"}, 32'(wb_rd_write_en), 32'(e.we));
      chk({tag, "_mis_ld"}, 32'(misaligned_load), 32'(e.ml));
      chk({tag, "_mis_st"}, 32'(misaligned_store), 32'(e.ms));
      chk({tag, "_bus_err"}, 32'(bus_error), 32'(e.be));
      if (e.chk_res) chk({tag, "_result"}, wb_result, e.res);
      if (e.ml || e.ms || e.be) chk({tag, "_fault_addr"}, fault_addr, e.fa);
    end
  endtask

  initial begin
    int n;
    logic last_stall;
    rst_n = 1'b0; in_valid = 1'b0; in_instr_id = '0; in_mem_addr = '0; in_store_data = '0;
    in_exec_result = '0; in_rd_addr = '0; in_rd_write_en = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    tick(); tick();
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Pass-through, then a second with rd=x0.
    push(32'h1234, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(ADD, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 1'b0, "add");
    chk("add_no_req", 32'(dmem_req), 32'd0);
    expect_wb("add");
    tick();
    chk("add_pulse_1cyc", 32'(wb_valid), 32'd0);
    chk("add_result_hold", wb_result, 32'h1234);
    push(32'h77, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(ADD, 32'h0, 32'h0, 32'h77, 5'd0, 1'b1, 1'b0, "add_x0");
    expect_wb("add_x0");

    // LB / LBU from lane 3 with ack at T+1.
    push(32'hFFFF_FF80, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(LB, 32'h1003, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, "lb");
    chk("lb_req", 32'(dmem_req), 32'd1);
    chk("lb_addr", dmem_addr, 32'h1000);
    chk("lb_wstrb", 32'(dmem_wstrb), 32'd0);
    chk("lb_we", 32'(dmem_we), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
    #1 chk("lb_ack_stall", 32'(stall_out), 32'd0);
    tick();
    dmem_ack = 1'b0;
    expect_wb("lb");
    chk("lb_req_drop", 32'(dmem_req), 32'd0);

    push(32'h0000_0080, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(LBU, 32'h1003, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1, "lbu");
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
    tick();
    dmem_ack = 1'b0;
    expect_wb("lbu");

    // SH to upper half, ack arrives 3 cycles after the request.
    push(32'h0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(SH, 32'h2002, 32'hABCD_5678, 32'h0, 5'd9, 1'b1, 1'b1, "sh");
    chk("sh_wdata", dmem_wdata, 32'h5678_5678);
    chk("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_stall_t1", 32'(stall_out), 32'd1);
    tick();
    chk("sh_stall_t2", 32'(stall_out), 32'd1);
    tick();
    dmem_ack = 1'b1;
    #1 chk("sh_stall_ack", 32'(stall_out), 32'd0);
    chk("sh_wdata_stable", dmem_wdata, 32'h5678_5678);
    tick();
    dmem_ack = 1'b0;
    expect_wb("sh");

    // Misaligned accesses never reach the bus.
    push(32'h0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3001);
    drive(LW, 32'h3001, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, "lw_mis");
    chk("lw_mis_no_req", 32'(dmem_req), 32'd0);
    expect_wb("lw_mis");
    push(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3002);
    drive(SW, 32'h3002, 32'h1, 32'h0, 5'd0, 1'b0, 1'b0, "sw_mis");
    chk("sw_mis_no_req", 32'(dmem_req), 32'd0);
    expect_wb("sw_mis");
    push(32'h0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3003);
    drive(LH, 32'h3003, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, "lh_mis");
    expect_wb("lh_mis");

    // Bus timeout: no ack ever.
    push(32'h0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000);
    drive(LW, 32'h4000, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1, "lw_to");
    n = 0;
    last_stall = 1'b1;
    while (dmem_req && n < 20) begin
      last_stall = stall_out;
      n++;
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'd5);
    chk("to_stall_release", 32'(last_stall), 32'd0);
    expect_wb("lw_to");
    push(32'h55, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(ADD, 32'h0, 32'h0, 32'h55, 5'd11, 1'b1, 1'b0, "add_after_to");
    expect_wb("add_after_to");

    // Ack on the very cycle the counter expires wins over the timeout.
    push(32'h1122_3344, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(LW, 32'h5004, 32'h0, 32'h0, 5'd12, 1'b1, 1'b1, "lw_race");
    tick(); tick(); tick(); tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
    #1 chk("race_req_held", 32'(dmem_req), 32'd1);
    tick();
    dmem_ack = 1'b0;
    expect_wb("lw_race");

    // Reset while waiting abandons the access.
    drive(LW, 32'h6000, 32'h0, 32'h0, 5'd13, 1'b1, 1'b1, "lw_rst");
    rst_n = 1'b0;
    tick();
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_stall", 32'(stall_out), 32'd0);
    rst_n = 1'b1;
    tick();

    push(32'hCAFE_F00D, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(LW, 32'h6008, 32'h0, 32'h0, 5'd14, 1'b1, 1'b1, "lw_post");
    chk("lw_post_addr", dmem_addr, 32'h6008);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0;
    expect_wb("lw_post");

    push(32'h0000_8001, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(LHU, 32'h6002, 32'h0, 32'h0, 5'd15, 1'b1, 1'b1, "lhu");
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
    tick();
    dmem_ack = 1'b0;
    expect_wb("lhu");
    push(32'hFFFF_8001, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(LH, 32'h6002, 32'h0, 32'h0, 5'd16, 1'b1, 1'b1, "lh");
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
    tick();
    dmem_ack = 1'b0;
    expect_wb("lh");

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
